arm_hps_system_pll_lock_sequencer: RTL
======================================

// Module: arm_hps_system_pll_lock_sequencer
// PURPOSE
//  Control end of the system PLL: drives the PLL rst input, watches its async
//  locked output, and releases system reset only after lock has been stable.
//  On lock timeout, re-pulses the PLL reset up to MAX_RETRIES times, then flags
//  failure. On lock loss while running, re-asserts system reset, counts the
//  event and restarts. Runs on the free-running reference clock, beside the PLL.
// PARAMETERS
//  PLL_RST_CYCLES      16     cycles pll_rst is held high per reset pulse (>=1)
//  LOCK_TIMEOUT        50000  max cycles in WAIT_LOCK before a retry (>=2)
//  LOCK_STABLE_CYCLES  1024   consecutive synced-lock cycles before release (>=1)
//  MAX_RETRIES         3      lock timeouts tolerated before FAIL (>=1)
// PORTS
//  clk            in   1  free-running reference clock (same source as PLL refclk)
//  reset_n        in   1  async active-low reset
//  pll_locked     in   1  PLL locked, asynchronous to clk
//  restart        in   1  1-cycle pulse: force a full PLL re-reset from any state
//  pll_rst        out  1  to PLL rst, active-high
//  sys_reset_n    out  1  downstream reset, active-low, registered
//  pll_fail       out  1  high while in FAIL
//  lock_loss_cnt  out  8  RUN->lock-lost events, saturating
//  state          out  3  FSM state (debug)
// BEHAVIOUR
//  Reset (reset_n=0): state=PLL_RST, pll_rst=1, sys_reset_n=0, pll_fail=0,
//   lock_loss_cnt=0, retry count=0, all timers=0, sync flops=0.
//  pll_locked passes through a 2-flop synchronizer -> lock_s (2-cycle latency).
//  Encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; all outputs registered.
//  PLL_RST: pll_rst=1, sys_reset_n=0; after PLL_RST_CYCLES cycles -> WAIT_LOCK.
//  WAIT_LOCK: pll_rst=0; timer counts. lock_s=1 -> STABLE (lock wins if same
//   cycle as timeout). Timer reaches LOCK_TIMEOUT-1: retry+=1; if new
//   retry==MAX_RETRIES -> FAIL, else -> PLL_RST.
//  STABLE: counts cycles with lock_s=1. lock_s=0 -> WAIT_LOCK, timer cleared, no
//   retry increment. Count reaches LOCK_STABLE_CYCLES-1 -> RUN; sys_reset_n=1
//   from the same edge; retry count cleared.
//  RUN: sys_reset_n=1, pll_rst=0. lock_s=0 -> PLL_RST: sys_reset_n=0 and
//   pll_rst=1 on that same edge; lock_loss_cnt+=1, saturating at 255.
//  FAIL: pll_rst=1, sys_reset_n=0, pll_fail=1; held until restart or reset_n.
//  restart=1 in any state (priority over all transitions) -> PLL_RST, retry=0,
//   timers=0, pll_fail=0; lock_loss_cnt kept. restart held high keeps PLL_RST.
//  sys_reset_n never high outside RUN; pll_rst never high in WAIT/STABLE/RUN.
//  Glitch on lock_s shorter than LOCK_STABLE_CYCLES in STABLE: no release.
//  reset_n low mid-operation: immediate async return to reset values.
// TESTING  (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
//  1 Release reset_n, pll_locked=1 from cycle 10 -> pll_rst high cycles 0-3;
//    sys_reset_n rises exactly 2+1+8 edges after locked rises; state=3.
//  2 pll_locked held 0 -> two 4-cycle pll_rst pulses 20 cycles apart, then
//    state=4, pll_fail=1, pll_rst=1, sys_reset_n stays 0; restart pulse -> state=0.
//  3 In STABLE, drop pll_locked 1 cycle after 5 locked cycles -> back to WAIT_LOCK,
//    no release; re-lock -> release 8 cycles after re-entering STABLE.
//  4 In RUN, drop pll_locked 300 times -> sys_reset_n low 3 edges after each drop
//    (2 sync + 1), pll_rst re-pulsed, lock_loss_cnt ends at 255 (saturated).
//  5 Timeout-and-lock same cycle in WAIT_LOCK -> STABLE, retry unchanged.
//  6 Assert reset_n low while in RUN and in FAIL -> all outputs at reset values
//    asynchronously, lock_loss_cnt=0.

Source files
------------

// File: rtl/arm_hps_system_pll_lock_sequencer.sv
// System PLL lock sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the downstream reset; retries on lock timeout and restarts on lock loss.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// PLL_RST    | pll_rst held high for PLL_RST_CYCLES cycles
// WAIT_LOCK  | pll_rst low, waiting up to LOCK_TIMEOUT cycles for lock_s
// STABLE     | lock_s seen, counting LOCK_STABLE_CYCLES consecutive lock cycles
// RUN        | system reset released, watching for lock loss
// FAIL       | retries exhausted, PLL held in reset until restart/reset_n
module arm_hps_system_pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       pll_fail,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // One shared timer serves every state; it is cleared on each state change.
    localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX   = (TMAX_A > LOCK_STABLE_CYCLES) ? TMAX_A : LOCK_STABLE_CYCLES;
    localparam int TW     = $clog2(TMAX);
    localparam int RW     = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    state_t          state_q;
    state_t          state_nxt;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_nxt;
    logic [RW-1:0]   retry_q;
    logic [RW-1:0]   retry_nxt;
    logic [RW-1:0]   retry_inc;
    logic [7:0]      loss_nxt;
    logic            sync_q;
    logic            lock_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lock_s <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PLL_RST;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign retry_inc = retry_q + RW'(1);

    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        retry_nxt = retry_q;
        loss_nxt  = lock_loss_cnt;
        if (restart) begin
            state_nxt = ST_PLL_RST;
            timer_nxt = '0;
            retry_nxt = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer_q + TW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a coincident timeout.
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        timer_nxt = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_nxt = '0;
                        retry_nxt = retry_inc;
                        state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                    end else begin
                        timer_nxt = timer_q + TW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        timer_nxt = '0;
                        retry_nxt = '0;
                    end else begin
                        timer_nxt = timer_q + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_PLL_RST;
                        timer_nxt = '0;
                        if (lock_loss_cnt != 8'hFF) begin
                            loss_nxt = lock_loss_cnt + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    timer_nxt = '0;
                end
                default: begin
                    state_nxt = ST_PLL_RST;
                    timer_nxt = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q       <= '0;
            retry_q       <= '0;
            lock_loss_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            pll_fail      <= 1'b0;
        end else begin
            timer_q       <= timer_nxt;
            retry_q       <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAIL);
            sys_reset_n   <= (state_nxt == ST_RUN);
            pll_fail      <= (state_nxt == ST_FAIL);
        end
    end

    assign state = state_q;

endmodule
